neuro_serial_frame: RTL

Parametrised serial framing front-end for the neuro-fuzzy inference core. It deserialises a one-time weight image and then a continuous stream of input samples from one serial pin, hands each sample to the compute core, and serialises the core's result back out on one serial pin. It generalises the fixed 250/14/13-bit serial protocol to configurable widths and gap length. It adds mid-run weight reload, a core-late error flag and optional input parity.

---
 rtl/neuro_serial_frame_if.sv | 29 ++
 rtl/neuro_serial_frame.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/neuro_serial_frame_if.sv
// Serial framing bundle: serial pins, weight image, sample and core result handshake.
// slave is the framing block's view; master is the core/line side.
interface neuro_serial_frame_if #(
    parameter int unsigned W_BITS   = 250,
    parameter int unsigned IN_BITS  = 14,
    parameter int unsigned OUT_BITS = 13
);
    logic                d_in_serial;
    logic                weight_reload;
    logic [OUT_BITS-1:0] result_in;
    logic                result_valid;
    logic                out_serial;
    logic [W_BITS-1:0]   weights;
    logic                weights_valid;
    logic [IN_BITS-1:0]  sample;
    logic                sample_valid;
    logic                late_err;
    logic                parity_err;

    modport slave (
        input  d_in_serial, weight_reload, result_in, result_valid,
        output out_serial, weights, weights_valid, sample, sample_valid, late_err, parity_err
    );

    modport master (
        output d_in_serial, weight_reload, result_in, result_valid,
        input  out_serial, weights, weights_valid, sample, sample_valid, late_err, parity_err
    );
endinterface

// File: rtl/neuro_serial_frame.sv
// Serial front-end for the neuro-fuzzy core: weight load, sample RX, result TX.
// Build option NEURO_SERIAL_PARITY_EN adds an even-parity bit after each sample.
module neuro_serial_frame #(
    parameter int unsigned W_BITS     = 250,
    parameter int unsigned IN_BITS    = 14,
    parameter int unsigned OUT_BITS   = 13,
    parameter int unsigned GAP_CYCLES = 1
) (
    input logic                  clk,
    input logic                  rst,
    neuro_serial_frame_if.slave  bus
);
`ifdef NEURO_SERIAL_PARITY_EN
    localparam int unsigned RX_BITS = IN_BITS + 1;
`else
    localparam int unsigned RX_BITS = IN_BITS;
`endif
    localparam int unsigned MAX_A = (W_BITS > IN_BITS + 1) ? W_BITS : IN_BITS + 1;
    localparam int unsigned MAX_B = (OUT_BITS > GAP_CYCLES) ? OUT_BITS : GAP_CYCLES;
    localparam int unsigned MAX_N = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W = $clog2(MAX_N + 1);

    typedef enum logic [1:0] {LOAD_W, RX_IN, GAP, TX_OUT} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [W_BITS-1:0]   weights_q, weights_d;
    logic                wvalid_q, wvalid_d;
    logic [IN_BITS-1:0]  shadow_q, shadow_d;
    logic [IN_BITS-1:0]  sample_q, sample_d;
    logic                svalid_q, svalid_d;
    logic [OUT_BITS-1:0] tx_q, tx_d;
    logic                out_q, out_d;
    logic                have_res_q, have_res_d;
    logic                bad_q, bad_d;
    logic                pend_q, pend_d;
    logic                late_q, late_d;
    logic                perr_q, perr_d;
    logic [OUT_BITS-1:0] tx_sel;
    logic                frame_end;

    // Next-state and datapath; the GAP->TX edge loads the first result bit directly.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        weights_d  = weights_q;
        wvalid_d   = wvalid_q;
        shadow_d   = shadow_q;
        sample_d   = sample_q;
        svalid_d   = 1'b0;
        tx_d       = tx_q;
        out_d      = 1'b0;
        have_res_d = have_res_q;
        bad_d      = bad_q;
        late_d     = late_q;
        perr_d     = perr_q;
        tx_sel     = '0;
        frame_end  = 1'b0;
        pend_d     = pend_q | (bus.weight_reload && (state_q != LOAD_W));

        case (state_q)
            LOAD_W: begin
                weights_d = W_BITS'({weights_q, bus.d_in_serial});
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W_BITS - 1)) begin
                    state_d  = RX_IN;
                    cnt_d    = '0;
                    wvalid_d = 1'b1;
                end
            end
            RX_IN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(RX_BITS - 1)) begin
                    state_d    = GAP;
                    cnt_d      = '0;
                    have_res_d = 1'b0;
                    bad_d      = 1'b0;
`ifdef NEURO_SERIAL_PARITY_EN
                    if (^{shadow_q, bus.d_in_serial}) begin
                        bad_d  = 1'b1;
                        perr_d = 1'b1;
                    end else begin
                        sample_d = shadow_q;
                        svalid_d = 1'b1;
                    end
`else
                    sample_d = IN_BITS'({shadow_q, bus.d_in_serial});
                    svalid_d = 1'b1;
`endif
                end else begin
                    shadow_d = IN_BITS'({shadow_q, bus.d_in_serial});
                end
            end
            GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.result_valid) begin
                    tx_d       = bus.result_in;
                    have_res_d = 1'b1;
                end
                if (cnt_q == CNT_W'(GAP_CYCLES)) begin
                    if (bad_q)                  tx_sel = '0;
                    else if (bus.result_valid)  tx_sel = bus.result_in;
                    else if (have_res_q)        tx_sel = tx_q;
                    else                        tx_sel = '0;
                    if (!bad_q && !bus.result_valid && !have_res_q) late_d = 1'b1;
                    out_d   = tx_sel[OUT_BITS-1];
                    tx_d    = tx_sel << 1;
                    state_d = TX_OUT;
                    cnt_d   = CNT_W'(1);
                    if (OUT_BITS == 1) frame_end = 1'b1;
                end
            end
            TX_OUT: begin
                out_d = tx_q[OUT_BITS-1];
                tx_d  = tx_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(OUT_BITS - 1)) frame_end = 1'b1;
            end
            default: state_d = LOAD_W;
        endcase

        // A pending reload is only honoured once the last result bit has been launched.
        if (frame_end) begin
            cnt_d = '0;
            if (pend_d) begin
                state_d  = LOAD_W;
                wvalid_d = 1'b0;
                pend_d   = 1'b0;
            end else begin
                state_d = RX_IN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= LOAD_W;
            cnt_q      <= '0;
            weights_q  <= '0;
            wvalid_q   <= 1'b0;
            shadow_q   <= '0;
            sample_q   <= '0;
            svalid_q   <= 1'b0;
            tx_q       <= '0;
            out_q      <= 1'b0;
            have_res_q <= 1'b0;
            bad_q      <= 1'b0;
            pend_q     <= 1'b0;
            late_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            weights_q  <= weights_d;
            wvalid_q   <= wvalid_d;
            shadow_q   <= shadow_d;
            sample_q   <= sample_d;
            svalid_q   <= svalid_d;
            tx_q       <= tx_d;
            out_q      <= out_d;
            have_res_q <= have_res_d;
            bad_q      <= bad_d;
            pend_q     <= pend_d;
            late_q     <= late_d;
            perr_q     <= perr_d;
        end
    end

    assign bus.out_serial    = out_q;
    assign bus.weights       = weights_q;
    assign bus.weights_valid = wvalid_q;
    assign bus.sample        = sample_q;
    assign bus.sample_valid  = svalid_q;
    assign bus.late_err      = late_q;
    assign bus.parity_err    = perr_q;
endmodule
